smbm_ctrl: RTL and testbench

Command initiator for the sorted multi-metric bookkeeping block (`smbm`). It accepts ADD, DELETE and READ requests on a valid/ready port and drives `smbm`'s opcode and argument inputs with the required one-cycle pulse. It waits for `smbm`'s `done`, and for READs scans the returned list chunk by chunk to report the first valid entry. It sits between the scheduler front-end and `smbm`, so the front-end never handles `smbm`'s state timing directly.

---
 rtl/smbm_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_smbm_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/smbm_ctrl.sv
// Command initiator for smbm: issues one-cycle opcode pulses, waits for done, scans READ results.
// Optional build macro SMBM_CTRL_TIMEOUT_EN adds a 255-cycle WAIT timeout reported on rsp_err.
module smbm_ctrl #(
    parameter int BIT_VEC_SIZE       = 512,
    parameter int BIT_VEC_SIZE_LOG   = 9,
    parameter int NUM_OF_METRICS     = 2,
    parameter int NUM_OF_METRICS_LOG = 1,
    parameter int SCAN_CHUNK         = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [1:0]                               req_op,
    input  logic [BIT_VEC_SIZE_LOG-1:0]              req_id,
    input  logic [8*NUM_OF_METRICS-1:0]              req_metric_val,
    input  logic [BIT_VEC_SIZE-1:0]                  req_mask,
    input  logic [NUM_OF_METRICS_LOG-1:0]            req_metricX,
    output logic [2:0]                               smbm_opcode,
    output logic [2:0]                               smbm_opcode_in,
    output logic [BIT_VEC_SIZE_LOG-1:0]              smbm_id,
    output logic [8*NUM_OF_METRICS-1:0]              smbm_metric_val,
    output logic [BIT_VEC_SIZE-1:0]                  smbm_in,
    output logic [NUM_OF_METRICS_LOG-1:0]            smbm_metricX,
    input  logic                                     smbm_done,
    input  logic [8*BIT_VEC_SIZE-1:0]                smbm_out_val,
    input  logic [BIT_VEC_SIZE_LOG*BIT_VEC_SIZE-1:0] smbm_out_ptr,
    output logic                                     rsp_valid,
    input  logic                                     rsp_ready,
    output logic [1:0]                               rsp_op,
    output logic                                     rsp_hit,
    output logic [BIT_VEC_SIZE_LOG-1:0]              rsp_idx,
    output logic [BIT_VEC_SIZE_LOG-1:0]              rsp_ptr,
    output logic [7:0]                               rsp_val,
    output logic                                     rsp_err
);

    localparam int NUM_CHUNKS = BIT_VEC_SIZE / SCAN_CHUNK;
    localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_SCAN, S_RESP} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_DEL, OP_READ_FILT, OP_READ_ALL} op_t;

    state_t                      state, state_next;
    op_t                         op_q;
    logic [CW-1:0]               chunk;
    logic                        armed;
    logic                        accept;
    logic                        op_is_read;

    logic                        scan_hit;
    logic [BIT_VEC_SIZE_LOG-1:0] scan_idx, scan_ptr, ent_idx;
    logic [7:0]                  scan_val;

    assign op_is_read = (op_q == OP_READ_FILT) || (op_q == OP_READ_ALL);
    assign rsp_op     = op_q;

`ifdef SMBM_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;
    assign timeout = (state == S_WAIT) && !smbm_done && (wait_cnt == 8'd254);
`else
    assign rsp_err = 1'b0;
`endif

    // Lowest-index entry in the current chunk whose val/ptr are not all ones.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        scan_ptr = '0;
        scan_val = '0;
        ent_idx  = '0;
        for (int i = 0; i < SCAN_CHUNK; i++) begin
            ent_idx = BIT_VEC_SIZE_LOG'(int'(chunk) * SCAN_CHUNK + i);
            if (!scan_hit &&
                !((&smbm_out_val[8*ent_idx +: 8]) &&
                  (&smbm_out_ptr[BIT_VEC_SIZE_LOG*ent_idx +: BIT_VEC_SIZE_LOG]))) begin
                scan_hit = 1'b1;
                scan_idx = ent_idx;
                scan_val = smbm_out_val[8*ent_idx +: 8];
                scan_ptr = smbm_out_ptr[BIT_VEC_SIZE_LOG*ent_idx +: BIT_VEC_SIZE_LOG];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        smbm_opcode = 3'b111;
        accept      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = armed;
                if (armed && req_valid) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (op_q)
                    OP_ADD:  smbm_opcode = 3'b000;
                    OP_DEL:  smbm_opcode = 3'b001;
                    default: smbm_opcode = 3'b010;
                endcase
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (smbm_done) state_next = op_is_read ? S_SETTLE : S_RESP;
`ifdef SMBM_CTRL_TIMEOUT_EN
                else if (timeout) state_next = S_RESP;
`endif
            end
            S_SETTLE: state_next = S_SCAN;
            S_SCAN: begin
                if (scan_hit || chunk == LAST_CHUNK) state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed           <= 1'b0;
            op_q            <= OP_ADD;
            chunk           <= '0;
            smbm_opcode_in  <= 3'b000;
            smbm_id         <= '0;
            smbm_metric_val <= '0;
            smbm_in         <= '0;
            smbm_metricX    <= '0;
            rsp_hit         <= 1'b0;
            rsp_idx         <= '0;
            rsp_ptr         <= '0;
            rsp_val         <= '0;
`ifdef SMBM_CTRL_TIMEOUT_EN
            wait_cnt        <= '0;
            rsp_err         <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            if (accept) begin
                op_q            <= op_t'(req_op);
                smbm_id         <= req_id;
                smbm_metric_val <= req_metric_val;
                smbm_in         <= req_mask;
                smbm_metricX    <= req_metricX;
                smbm_opcode_in  <= (req_op == 2'b10) ? 3'b010 :
                                   (req_op == 2'b11) ? 3'b101 : 3'b000;
                chunk           <= '0;
                rsp_hit         <= 1'b0;
                rsp_idx         <= '0;
                rsp_ptr         <= '0;
                rsp_val         <= '0;
`ifdef SMBM_CTRL_TIMEOUT_EN
                wait_cnt        <= '0;
                rsp_err         <= 1'b0;
`endif
            end
`ifdef SMBM_CTRL_TIMEOUT_EN
            if (state == S_WAIT && !smbm_done) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (timeout) rsp_err <= 1'b1;
            end
`endif
            if (state == S_SCAN) begin
                if (scan_hit) begin
                    rsp_hit <= 1'b1;
                    rsp_idx <= scan_idx;
                    rsp_ptr <= scan_ptr;
                    rsp_val <= scan_val;
                end else if (chunk != LAST_CHUNK) begin
                    chunk <= chunk + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_smbm_ctrl.sv
// Directed bench for smbm_ctrl; the bench itself plays smbm, driving done and out_list by hand.
module tb_smbm_ctrl;

    localparam int BVS  = 512;
    localparam int BVSL = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [1:0]        req_op;
    logic [BVSL-1:0]   req_id;
    logic [15:0]       req_metric_val;
    logic [BVS-1:0]    req_mask;
    logic [0:0]        req_metricX;
    logic [2:0]        smbm_opcode, smbm_opcode_in;
    logic [BVSL-1:0]   smbm_id;
    logic [15:0]       smbm_metric_val;
    logic [BVS-1:0]    smbm_in;
    logic [0:0]        smbm_metricX;
    logic              smbm_done;
    logic [8*BVS-1:0]  smbm_out_val;
    logic [BVSL*BVS-1:0] smbm_out_ptr;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_op;
    logic              rsp_hit;
    logic [BVSL-1:0]   rsp_idx, rsp_ptr;
    logic [7:0]        rsp_val;
    logic              rsp_err;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    smbm_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
        .req_metric_val(req_metric_val), .req_mask(req_mask), .req_metricX(req_metricX),
        .smbm_opcode(smbm_opcode), .smbm_opcode_in(smbm_opcode_in), .smbm_id(smbm_id),
        .smbm_metric_val(smbm_metric_val), .smbm_in(smbm_in), .smbm_metricX(smbm_metricX),
        .smbm_done(smbm_done), .smbm_out_val(smbm_out_val), .smbm_out_ptr(smbm_out_ptr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx), .rsp_ptr(rsp_ptr), .rsp_val(rsp_val), .rsp_err(rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start_req(input logic [1:0] op, input logic [BVSL-1:0] id,
                             input logic [15:0] mv, input logic [BVS-1:0] mask,
                             input logic mx);
        req_valid      = 1'b1;
        req_op         = op;
        req_id         = id;
        req_metric_val = mv;
        req_mask       = mask;
        req_metricX    = mx;
    endtask

    task automatic clear_list();
        smbm_out_val = '1;
        smbm_out_ptr = '1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_id = '0; req_metric_val = '0;
        req_mask = '0; req_metricX = '0; smbm_done = 1'b0; rsp_ready = 1'b0;
        clear_list();

        // Reset state
        ticks(2);
        check("rst req_ready", req_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst opcode", smbm_opcode, 3'b111);
        check("rst opcode_in", smbm_opcode_in, 0);
        check("rst rsp_err", rsp_err, 0);
        rst = 1'b0;
        tick();
        check("post-rst req_ready", req_ready, 1);
        check("post-rst opcode", smbm_opcode, 3'b111);
        check("post-rst rsp_valid", rsp_valid, 0);

        // ADD id=5, metrics {10,20}; done in cycle 3
        start_req(2'b00, 9'd5, {8'd20, 8'd10}, '0, 1'b0);
        check("add c0 req_ready", req_ready, 1);
        tick(); req_valid = 1'b0;
        check("add c1 opcode", smbm_opcode, 3'b000);
        check("add c1 id", smbm_id, 5);
        check("add c1 metric", smbm_metric_val, 16'h140A);
        check("add c1 req_ready", req_ready, 0);
        tick();
        check("add c2 opcode", smbm_opcode, 3'b111);
        tick(); smbm_done = 1'b1;
        check("add c3 rsp_valid", rsp_valid, 0);
        tick(); smbm_done = 1'b0;
        check("add c4 rsp_valid", rsp_valid, 1);
        check("add c4 rsp_hit", rsp_hit, 0);
        check("add c4 rsp_op", rsp_op, 2'b00);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        check("add done rsp_valid", rsp_valid, 0);
        check("add done req_ready", req_ready, 1);

        // READ all: first valid entry 130 (ptr 7, val 42), later valid entries ignored
        clear_list();
        smbm_out_val[130*8 +: 8]       = 8'd42;
        smbm_out_ptr[130*BVSL +: BVSL] = 9'd7;
        smbm_out_val[150*8 +: 8]       = 8'd1;
        smbm_out_ptr[150*BVSL +: BVSL] = 9'd1;
        smbm_out_val[200*8 +: 8]       = 8'd3;
        smbm_out_ptr[200*BVSL +: BVSL] = 9'd3;
        start_req(2'b11, 9'd0, 16'h0, 512'hA5, 1'b1);
        tick(); req_valid = 1'b0;
        check("rda c1 opcode", smbm_opcode, 3'b010);
        check("rda c1 opcode_in", smbm_opcode_in, 3'b101);
        check("rda c1 metricX", smbm_metricX, 1);
        check("rda c1 smbm_in", smbm_in[63:0], 64'hA5);
        tick(); smbm_done = 1'b1;
        check("rda c2 opcode", smbm_opcode, 3'b111);
        tick(); smbm_done = 1'b0;
        check("rda c3 rsp_valid", rsp_valid, 0);
        ticks(3);
        check("rda c6 rsp_valid", rsp_valid, 0);
        tick();
        check("rda c7 rsp_valid", rsp_valid, 1);
        check("rda c7 rsp_hit", rsp_hit, 1);
        check("rda c7 rsp_idx", rsp_idx, 130);
        check("rda c7 rsp_ptr", rsp_ptr, 7);
        check("rda c7 rsp_val", rsp_val, 42);
        check("rda c7 rsp_op", rsp_op, 2'b11);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // READ filtered, every entry all ones: miss in cycle 12
        clear_list();
        start_req(2'b10, 9'd0, 16'h0, '1, 1'b0);
        tick(); req_valid = 1'b0;
        check("rdf c1 opcode", smbm_opcode, 3'b010);
        check("rdf c1 opcode_in", smbm_opcode_in, 3'b010);
        tick(); smbm_done = 1'b1;
        tick(); smbm_done = 1'b0;
        ticks(8);
        check("rdf c11 rsp_valid", rsp_valid, 0);
        tick();
        check("rdf c12 rsp_valid", rsp_valid, 1);
        check("rdf c12 rsp_hit", rsp_hit, 0);
        check("rdf c12 rsp_idx", rsp_idx, 0);
        check("rdf c12 rsp_ptr", rsp_ptr, 0);
        check("rdf c12 rsp_val", rsp_val, 0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // DELETE id=5 with rsp_ready held low; a competing request is held pending
        start_req(2'b01, 9'd5, 16'h0, '0, 1'b0);
        tick(); req_valid = 1'b0;
        check("del c1 opcode", smbm_opcode, 3'b001);
        tick();
        tick(); smbm_done = 1'b1;
        tick(); smbm_done = 1'b0;
        start_req(2'b00, 9'd9, 16'h0102, '0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            check("stall rsp_valid", rsp_valid, 1);
            check("stall req_ready", req_ready, 0);
            check("stall rsp_op", rsp_op, 2'b01);
            check("stall smbm_id", smbm_id, 5);
            check("stall opcode", smbm_opcode, 3'b111);
            tick();
        end
        rsp_ready = 1'b1;
        check("hs rsp_valid", rsp_valid, 1);
        check("hs req_ready", req_ready, 0);
        tick(); rsp_ready = 1'b0;
        check("post-hs req_ready", req_ready, 1);
        check("post-hs opcode", smbm_opcode, 3'b111);
        check("post-hs smbm_id", smbm_id, 5);
        tick(); req_valid = 1'b0;
        check("pend c1 opcode", smbm_opcode, 3'b000);
        check("pend c1 smbm_id", smbm_id, 9);
        tick();
        tick(); smbm_done = 1'b1;
        tick(); smbm_done = 1'b0;
        check("pend c4 rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Reset mid-WAIT
        start_req(2'b00, 9'd3, 16'h0, '0, 1'b0);
        tick(); req_valid = 1'b0;
        ticks(20);
        check("wait c21 rsp_valid", rsp_valid, 0);
        rst = 1'b1; #1;
        check("wait-rst req_ready", req_ready, 0);
        check("wait-rst opcode", smbm_opcode, 3'b111);
        check("wait-rst smbm_id", smbm_id, 0);
        tick(); rst = 1'b0;
        tick();
        check("wait-rst idle", req_ready, 1);

        // Reset while holding a response
        start_req(2'b00, 9'd4, 16'h0, '0, 1'b0);
        tick(); req_valid = 1'b0;
        tick();
        tick(); smbm_done = 1'b1;
        tick(); smbm_done = 1'b0;
        check("resp-rst pre rsp_valid", rsp_valid, 1);
        rst = 1'b1; #1;
        check("resp-rst rsp_valid", rsp_valid, 0);
        tick(); rst = 1'b0;
        tick();
        check("resp-rst idle", req_ready, 1);

`ifdef SMBM_CTRL_TIMEOUT_EN
        // Timeout: 255 WAIT cycles (2..256) without done, RESP with err in cycle 257
        start_req(2'b00, 9'd6, 16'h0, '0, 1'b0);
        tick(); req_valid = 1'b0;
        ticks(255);
        check("to c256 rsp_valid", rsp_valid, 0);
        tick();
        check("to c257 rsp_valid", rsp_valid, 1);
        check("to c257 rsp_err", rsp_err, 1);
        check("to c257 rsp_hit", rsp_hit, 0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        check("to done req_ready", req_ready, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
